imc_wb_initiator: RTL and testbench

IMC_WB_INITIATOR -- requirements
Module: imc_wb_initiator

---
 rtl/imc_wb_pkg.sv | 33 +++
 rtl/imc_wb_timer.sv | 44 ++++
 rtl/imc_wb_initiator.sv | 206 ++++++++++++++++++++
 tb/tb_imc_wb_initiator.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imc_wb_pkg.sv
// ---------------------------------------------------------------------------
// imc_wb_pkg
// Shared definitions for the Wishbone classic burst initiator:
//   - wb_state_e      : initiator FSM state encoding (also exported on the
//                       debug state port of the top)
//   - ADDR_STRIDE_DEF : default byte increment between beats
//   - BEAT_W          : width of the beat-count field (beats minus one)
//   - TIMER_W         : width of the per-beat ack-wait counter
//   - next_addr()     : address step, wraps modulo 2^32
// ---------------------------------------------------------------------------
package imc_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_REQ   = 2'd2,
    ST_RESP  = 2'd3
  } wb_state_e;

  localparam int unsigned ADDR_STRIDE_DEF = 4;
  localparam int unsigned BEAT_W          = 8;
  localparam int unsigned TIMER_W         = 16;

  localparam logic [BEAT_W-1:0] BEAT_ONE = {{(BEAT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]        SEL_ALL  = 4'hF;

  // Plain 32-bit add: carry out is discarded, so the address wraps silently.
  function automatic logic [31:0] next_addr(input logic [31:0] adr,
                                            input logic [31:0] stride);
    return adr + stride;
  endfunction

endpackage

// File: rtl/imc_wb_timer.sv
// ---------------------------------------------------------------------------
// imc_wb_timer
// Per-beat ack-wait counter. Counts clock cycles while i_run is high and
// restarts from zero whenever i_run drops, so every beat gets a fresh budget.
// o_expired is high in the LIMIT-th consecutive cycle of i_run, which lets the
// owner leave its wait state on that edge: the waited-on strobe is then high
// for exactly LIMIT cycles. With ENABLE=0 the output is constant 0 and the
// counter has no load.
//
// Ports:
//   i_clk      in  1  clock, rising edge
//   i_rst      in  1  asynchronous reset, active high
//   i_run      in  1  count enable (initiator is waiting for ack)
//   o_expired  out 1  budget exhausted this cycle
// ---------------------------------------------------------------------------
module imc_wb_timer
  import imc_wb_pkg::*;
#(
  parameter int unsigned LIMIT  = 255,
  parameter bit          ENABLE = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  output logic o_expired
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

  logic [TIMER_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + {{(TIMER_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_expired = ENABLE && i_run && (r_cnt == LAST);

endmodule

// File: rtl/imc_wb_initiator.sv
// ---------------------------------------------------------------------------
// imc_wb_initiator
// Turns a burst command (start address, beat count) into a sequence of
// single-beat Wishbone classic cycles. Writes pull one word per beat from the
// write-data stream; reads push one word per beat onto the read-data stream.
// cyc/stb drop for at least one cycle between beats (FETCH or RESP sits in
// between), so every beat is an independent classic cycle.
//
// Build option: define IMC_WB_TIMEOUT_EN to abandon a burst when a beat waits
// TIMEOUT_CYCLES cycles without ack (err_o then sets and stays set until the
// next command is accepted). Without it the initiator waits forever and
// err_o is constant 0.
//
// Handshakes: every stream (cmd, wr, rd) transfers on a rising edge where
// valid and ready are both high; valid never waits on ready, and a source
// holds its payload stable while valid is high and ready is low.
//
// Ports:
//   wb_clk_i, wb_rst_i               clock, async active-high reset
//   cmd_valid_i/cmd_ready_o          command handshake
//   cmd_we_i, cmd_adr_i, cmd_len_i   direction, start byte address, beats-1
//   wr_valid_i/wr_ready_o/wr_data_i  write-data stream (into initiator)
//   rd_valid_o/rd_ready_i/rd_data_o  read-data stream (out of initiator)
//   wbm_*                            Wishbone classic master port
//   busy_o                           burst in progress (state != IDLE)
//   err_o                            sticky timeout error
//   dbg_state_o                      current FSM state (wb_state_e encoding)
// ---------------------------------------------------------------------------
module imc_wb_initiator
  import imc_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_STRIDE    = ADDR_STRIDE_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [31:0]       cmd_adr_i,
  input  logic [BEAT_W-1:0] cmd_len_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [31:0]       wr_data_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [31:0]       rd_data_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [31:0]       wbm_adr_o,
  output logic [31:0]       wbm_dat_o,
  output logic [3:0]        wbm_sel_o,
  input  logic [31:0]       wbm_dat_i,
  input  logic              wbm_ack_i,
  output logic              busy_o,
  output logic              err_o,
  output logic [1:0]        dbg_state_o
);

`ifdef IMC_WB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  wb_state_e         r_state;
  wb_state_e         w_state_nxt;
  logic              r_we;
  logic [31:0]       r_adr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [BEAT_W-1:0] r_left;     // beats remaining after the current one

  logic w_in_req;
  logic w_cmd_fire;
  logic w_wr_fire;
  logic w_ack;
  logic w_rd_fire;
  logic w_last;
  logic w_timeout;
  logic [31:0] w_adr_next;

  assign w_in_req   = (r_state == ST_REQ);
  assign w_cmd_fire = (r_state == ST_IDLE)  && cmd_valid_i;
  assign w_wr_fire  = (r_state == ST_FETCH) && wr_valid_i;
  // Ack only counts while the strobe is out; stray acks elsewhere are ignored.
  assign w_ack      = w_in_req && wbm_ack_i;
  assign w_rd_fire  = (r_state == ST_RESP)  && rd_ready_i;
  assign w_last     = (r_left == '0);
  assign w_adr_next = next_addr(r_adr, 32'(ADDR_STRIDE));

  imc_wb_timer #(
    .LIMIT  (TIMEOUT_CYCLES),
    .ENABLE (TIMEOUT_EN)
  ) u_timer (
    .i_clk     (wb_clk_i),
    .i_rst     (wb_rst_i),
    .i_run     (w_in_req),
    .o_expired (w_timeout)
  );

  // Next-state logic. Ack wins over an expiring timer in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          w_state_nxt = cmd_we_i ? ST_FETCH : ST_REQ;
        end
      end
      ST_FETCH: begin
        if (wr_valid_i) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (wbm_ack_i) begin
          if (!r_we) begin
            w_state_nxt = ST_RESP;
          end else if (w_last) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (rd_ready_i) begin
          w_state_nxt = w_last ? ST_IDLE : ST_REQ;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_left  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cmd_fire) begin
        r_we   <= cmd_we_i;
        r_adr  <= cmd_adr_i;
        r_left <= cmd_len_i;
      end
      if (w_wr_fire) begin
        r_wdata <= wr_data_i;
      end
      // A write beat advances on ack; a read beat advances once its data
      // has been handed off, so the address stays valid for the whole beat.
      if (w_ack) begin
        if (!r_we) begin
          r_rdata <= wbm_dat_i;
        end else if (!w_last) begin
          r_adr  <= w_adr_next;
          r_left <= r_left - BEAT_ONE;
        end
      end
      if (w_rd_fire && !w_last) begin
        r_adr  <= w_adr_next;
        r_left <= r_left - BEAT_ONE;
      end
    end
  end

`ifdef IMC_WB_TIMEOUT_EN
  logic r_err;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_err <= 1'b0;
    end else if (w_cmd_fire) begin
      r_err <= 1'b0;
    end else if (w_in_req && !wbm_ack_i && w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  // cmd_ready is gated by reset so every output reads 0 while reset is held.
  assign cmd_ready_o = (r_state == ST_IDLE) && !wb_rst_i;
  assign wr_ready_o  = (r_state == ST_FETCH);
  assign rd_valid_o  = (r_state == ST_RESP);
  assign rd_data_o   = r_rdata;
  assign wbm_cyc_o   = w_in_req;
  assign wbm_stb_o   = w_in_req;
  assign wbm_we_o    = w_in_req && r_we;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_wdata;
  assign wbm_sel_o   = w_in_req ? SEL_ALL : 4'h0;
  assign busy_o      = (r_state != ST_IDLE);
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_imc_wb_initiator.sv
// ---------------------------------------------------------------------------
// tb_imc_wb_initiator
// Directed bench for imc_wb_initiator (TIMEOUT_CYCLES=8, ADDR_STRIDE=4).
// Inputs change and outputs are sampled on the falling clock edge.
// With IMC_WB_TIMEOUT_EN defined the timeout step checks the abandon path;
// otherwise it checks that the initiator keeps waiting.
// ---------------------------------------------------------------------------
module tb_imc_wb_initiator;

  localparam int unsigned TO_CYC = 8;

  // ---------------- clock / reset ----------------
  logic        wb_clk_i    = 1'b0;
  logic        wb_rst_i    = 1'b1;

  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i    = 1'b0;
  logic [31:0] cmd_adr_i   = '0;
  logic [7:0]  cmd_len_i   = '0;
  logic        wr_valid_i  = 1'b0;
  logic        wr_ready_o;
  logic [31:0] wr_data_i   = '0;
  logic        rd_valid_o;
  logic        rd_ready_i  = 1'b0;
  logic [31:0] rd_data_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i   = '0;
  logic        wbm_ack_i   = 1'b0;
  logic        busy_o;
  logic        err_o;
  logic [1:0]  dbg_state_o;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];

  always #5 wb_clk_i = ~wb_clk_i;

  imc_wb_initiator #(
    .TIMEOUT_CYCLES (TO_CYC),
    .ADDR_STRIDE    (4)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_adr_i   (cmd_adr_i),
    .cmd_len_i   (cmd_len_i),
    .wr_valid_i  (wr_valid_i),
    .wr_ready_o  (wr_ready_o),
    .wr_data_i   (wr_data_i),
    .rd_valid_o  (rd_valid_o),
    .rd_ready_i  (rd_ready_i),
    .rd_data_o   (rd_data_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack_i),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (entered and left on a falling edge) ----------------
  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [7:0] len);
    for (int i = 0; i < 50 && !cmd_ready_o; i++) @(negedge wb_clk_i);
    chk("cmd_ready", cmd_ready_o, 1);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_len_i   = len;
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
    chk("busy_after_accept", busy_o, 1);
  endtask

  task automatic drive_wr(input logic [31:0] data);
    wr_valid_i = 1'b1;
    wr_data_i  = data;
    for (int i = 0; i < 50 && !wr_ready_o; i++) @(negedge wb_clk_i);
    chk("wr_ready", wr_ready_o, 1);
    @(negedge wb_clk_i);
    wr_valid_i = 1'b0;
    wr_data_i  = '0;
    chk("wr_ready_drop", wr_ready_o, 0);
  endtask

  // Responder for one beat: check the request, hold ack off for 'delay'
  // cycles, then ack once and check the strobe drops afterwards.
  task automatic wb_beat(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input int delay, input logic [31:0] rdata);
    for (int i = 0; i < 50 && !wbm_stb_o; i++) @(negedge wb_clk_i);
    chk("stb_seen", wbm_stb_o, 1);
    chk("cyc", wbm_cyc_o, 1);
    chk("we", wbm_we_o, we);
    chk("adr", wbm_adr_o, adr);
    chk("sel", wbm_sel_o, 4'hF);
    if (we) chk("dat_o", wbm_dat_o, dat);
    for (int k = 0; k < delay; k++) begin
      @(negedge wb_clk_i);
      chk("stb_hold", wbm_stb_o, 1);
      chk("adr_hold", wbm_adr_o, adr);
    end
    wbm_ack_i = 1'b1;
    wbm_dat_i = rdata;
    @(negedge wb_clk_i);
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    chk("stb_gap", wbm_stb_o, 0);
    chk("cyc_gap", wbm_cyc_o, 0);
  endtask

  // Read-data sink: compare against the scoreboard, stall 'stall' cycles
  // (with a stray ack each stall cycle, which must be ignored), then accept.
  task automatic rd_take(input int stall);
    logic [31:0] e;
    for (int i = 0; i < 50 && !rd_valid_o; i++) @(negedge wb_clk_i);
    chk("rd_valid", rd_valid_o, 1);
    e = exp_q.pop_front();
    chk("rd_data", rd_data_o, e);
    for (int k = 0; k < stall; k++) begin
      wbm_ack_i = 1'b1;
      @(negedge wb_clk_i);
      chk("rd_hold", rd_data_o, e);
      chk("rd_valid_hold", rd_valid_o, 1);
      chk("no_stb_stall", wbm_stb_o, 0);
    end
    wbm_ack_i  = 1'b0;
    rd_ready_i = 1'b1;
    @(negedge wb_clk_i);
    rd_ready_i = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    repeat (2) @(negedge wb_clk_i);
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_stb", wbm_stb_o, 0);
    chk("rst_cmd_ready", cmd_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_wr_ready", wr_ready_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_sel", wbm_sel_o, 0);
    wb_rst_i = 1'b0;
    #1;
    chk("rel_cmd_ready", cmd_ready_o, 1);
    @(negedge wb_clk_i);

    // Stray ack while idle
    wbm_ack_i = 1'b1;
    @(negedge wb_clk_i);
    wbm_ack_i = 1'b0;
    chk("idle_ack_busy", busy_o, 0);
    chk("idle_ack_state", dbg_state_o, 2'd0);

    // Single write, ack after 2 cycles
    send_cmd(1'b1, 32'h3000_0000, 8'd0);
    chk("wr_fetch_state", dbg_state_o, 2'd1);
    chk("wr_fetch_no_stb", wbm_stb_o, 0);
    drive_wr(32'hA5A5_0001);
    wb_beat(1'b1, 32'h3000_0000, 32'hA5A5_0001, 2, 32'h0);
    chk("wr_busy_drop", busy_o, 0);

    // Read burst of 4 with backpressure on beat 2
    exp_q.push_back(32'h11);
    exp_q.push_back(32'h22);
    exp_q.push_back(32'h33);
    exp_q.push_back(32'h44);
    send_cmd(1'b0, 32'h3000_0010, 8'd3);
    chk("rd_first_stb_latency", wbm_stb_o, 1);
    wb_beat(1'b0, 32'h3000_0010, 32'h0, 1, 32'h11);
    rd_take(0);
    wb_beat(1'b0, 32'h3000_0014, 32'h0, 0, 32'h22);
    rd_take(5);
    wb_beat(1'b0, 32'h3000_0018, 32'h0, 3, 32'h33);
    rd_take(1);
    wb_beat(1'b0, 32'h3000_001C, 32'h0, 0, 32'h44);
    rd_take(0);
    chk("rd_busy_drop", busy_o, 0);
    chk("rd_scoreboard_empty", exp_q.size(), 0);

    // Address wrap on a two-beat write
    send_cmd(1'b1, 32'hFFFF_FFFC, 8'd1);
    drive_wr(32'hDEAD_0001);
    wb_beat(1'b1, 32'hFFFF_FFFC, 32'hDEAD_0001, 0, 32'h0);
    chk("wrap_busy_mid", busy_o, 1);
    drive_wr(32'hDEAD_0002);
    wb_beat(1'b1, 32'h0000_0000, 32'hDEAD_0002, 1, 32'h0);
    chk("wrap_busy_drop", busy_o, 0);
    chk("wrap_err", err_o, 0);

    // Missing ack
`ifdef IMC_WB_TIMEOUT_EN
    begin
      int hi;
      hi = 0;
      send_cmd(1'b0, 32'h4000_0000, 8'd2);
      for (int i = 0; i < 40 && wbm_stb_o; i++) begin
        hi++;
        @(negedge wb_clk_i);
      end
      chk("to_stb_cycles", hi, TO_CYC);
      chk("to_err_set", err_o, 1);
      chk("to_busy_drop", busy_o, 0);
      chk("to_cyc_drop", wbm_cyc_o, 0);
      exp_q.push_back(32'h0000_BEEF);
      send_cmd(1'b0, 32'h4000_0100, 8'd0);
      chk("to_err_cleared", err_o, 0);
      wb_beat(1'b0, 32'h4000_0100, 32'h0, 0, 32'h0000_BEEF);
      rd_take(0);
    end
`else
    send_cmd(1'b0, 32'h4000_0000, 8'd0);
    repeat (20) @(negedge wb_clk_i);
    chk("wait_stb_held", wbm_stb_o, 1);
    chk("wait_err_zero", err_o, 0);
    chk("wait_busy", busy_o, 1);
    exp_q.push_back(32'hCAFE_0000);
    wb_beat(1'b0, 32'h4000_0000, 32'h0, 0, 32'hCAFE_0000);
    rd_take(0);
`endif
    chk("after_wait_busy", busy_o, 0);

    // Reset mid-REQ, then a fresh command
    send_cmd(1'b0, 32'h5000_0000, 8'd1);
    chk("mid_stb_up", wbm_stb_o, 1);
    #2 wb_rst_i = 1'b1;
    #1;
    chk("midrst_stb", wbm_stb_o, 0);
    chk("midrst_cyc", wbm_cyc_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_cmd_ready", cmd_ready_o, 0);
    chk("midrst_state", dbg_state_o, 2'd0);
    @(negedge wb_clk_i);
    chk("midrst_quiet", wbm_stb_o, 0);
    wb_rst_i = 1'b0;
    #1;
    chk("midrst_rel_ready", cmd_ready_o, 1);
    @(negedge wb_clk_i);
    send_cmd(1'b1, 32'h5000_0040, 8'd0);
    drive_wr(32'h1234_5678);
    wb_beat(1'b1, 32'h5000_0040, 32'h1234_5678, 1, 32'h0);
    chk("post_rst_busy", busy_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
